aexm_lsu: RTL and testbench

Data-side load/store stage of the aexm core, directly downstream of the execute unit. It captures the effective address and byte-lane select that execute produces for load and store instructions. It runs a request/acknowledge transaction with the data cache and stalls the pipeline until the cache responds. It returns right-aligned, zero-extended load data to writeback with its destination register.

---
 rtl/aexm_lsu.sv | 147 ++++++++++++++
 tb/tb_aexm_lsu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/aexm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : aexm_lsu
// Brief    : aexm data-side load/store stage: issues cache request/ack
//            transactions, stalls the pipeline, returns aligned load data.
//            Optional bus timeout enabled by defining AEXM_LSU_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module aexm_lsu #(
  parameter int DW = 32
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_en,
  input  logic          xLSU_LD,
  input  logic          xLSU_ST,
  input  logic [DW-1:0] rRESULT,
  input  logic [3:0]    rDWBSEL,
  input  logic [DW-1:0] xSTDATA,
  input  logic [4:0]    rRD,
  output logic          dc_req,
  output logic          dc_we,
  output logic [29:0]   dc_addr,
  output logic [3:0]    dc_sel,
  output logic [DW-1:0] dc_wdat,
  input  logic          dc_ack,
  input  logic [DW-1:0] dc_rdat,
  output logic          lsu_stall,
  output logic [DW-1:0] wLDDAT,
  output logic [4:0]    wLDRD,
  output logic          wLDWE,
  output logic          lsu_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state;
  logic [4:0]    r_rd;
  logic          w_issue;
  logic [DW-1:0] w_ldAlign;
  logic [DW-1:0] w_stRep;

  // A select of 0 is an FSL access and never reaches the cache.
  assign w_issue   = x_en & (xLSU_LD | xLSU_ST) & (rDWBSEL != 4'h0) & (r_state != REQ);
  assign lsu_stall = (r_state == REQ) & ~dc_ack;

  always_comb begin
    w_ldAlign = '0;
    case (dc_sel)
      4'h8:    w_ldAlign = {{(DW-8){1'b0}},  dc_rdat[31:24]};
      4'h4:    w_ldAlign = {{(DW-8){1'b0}},  dc_rdat[23:16]};
      4'h2:    w_ldAlign = {{(DW-8){1'b0}},  dc_rdat[15:8]};
      4'h1:    w_ldAlign = {{(DW-8){1'b0}},  dc_rdat[7:0]};
      4'hC:    w_ldAlign = {{(DW-16){1'b0}}, dc_rdat[31:16]};
      4'h3:    w_ldAlign = {{(DW-16){1'b0}}, dc_rdat[15:0]};
      4'hF:    w_ldAlign = dc_rdat;
      default: w_ldAlign = '0;
    endcase
  end

  always_comb begin
    w_stRep = xSTDATA;
    case (rDWBSEL)
      4'h8, 4'h4, 4'h2, 4'h1: w_stRep = {4{xSTDATA[7:0]}};
      4'hC, 4'h3:             w_stRep = {2{xSTDATA[15:0]}};
      default:                w_stRep = xSTDATA;
    endcase
  end

`ifdef AEXM_LSU_TIMEOUT_EN
  logic [7:0] r_toCnt;
`else
  assign lsu_err = 1'b0;
`endif

  always_ff @(posedge gclk or posedge grst) begin
    if (grst) begin
      r_state <= IDLE;
      r_rd    <= '0;
      dc_req  <= 1'b0;
      dc_we   <= 1'b0;
      dc_addr <= '0;
      dc_sel  <= '0;
      dc_wdat <= '0;
      wLDDAT  <= '0;
      wLDRD   <= '0;
      wLDWE   <= 1'b0;
`ifdef AEXM_LSU_TIMEOUT_EN
      r_toCnt <= '0;
      lsu_err <= 1'b0;
`endif
    end else begin
      wLDWE <= 1'b0;
      case (r_state)
        REQ: begin
          if (dc_ack) begin
            dc_req <= 1'b0;
            if (!dc_we) begin
              wLDDAT  <= w_ldAlign;
              wLDRD   <= r_rd;
              wLDWE   <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= IDLE;
            end
          end
`ifdef AEXM_LSU_TIMEOUT_EN
          else if (r_toCnt == 8'hFF) begin
            // Abandon the access; a load still retires with an all-ones result.
            dc_req  <= 1'b0;
            r_state <= IDLE;
            lsu_err <= 1'b1;
            if (!dc_we) begin
              wLDDAT <= '1;
              wLDRD  <= r_rd;
              wLDWE  <= 1'b1;
            end
          end else begin
            r_toCnt <= r_toCnt + 8'd1;
          end
`endif
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase

      if (w_issue) begin
        r_state <= REQ;
        dc_req  <= 1'b1;
        dc_we   <= xLSU_ST & ~xLSU_LD;
        dc_addr <= rRESULT[31:2];
        dc_sel  <= rDWBSEL;
        dc_wdat <= w_stRep;
        r_rd    <= rRD;
`ifdef AEXM_LSU_TIMEOUT_EN
        r_toCnt <= '0;
`endif
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aexm_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_aexm_lsu
// Brief    : self-checking bench for aexm_lsu; load results are scoreboarded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aexm_lsu;

  logic        gclk = 1'b0;
  logic        grst;
  logic        x_en, xLSU_LD, xLSU_ST;
  logic [31:0] rRESULT, xSTDATA, dc_rdat;
  logic [3:0]  rDWBSEL;
  logic [4:0]  rRD;
  logic        dc_req, dc_we, dc_ack, lsu_stall, wLDWE, lsu_err;
  logic [29:0] dc_addr;
  logic [3:0]  dc_sel;
  logic [31:0] dc_wdat, wLDDAT;
  logic [4:0]  wLDRD;

  aexm_lsu #(.DW(32)) dut (
    .gclk(gclk), .grst(grst), .x_en(x_en), .xLSU_LD(xLSU_LD), .xLSU_ST(xLSU_ST),
    .rRESULT(rRESULT), .rDWBSEL(rDWBSEL), .xSTDATA(xSTDATA), .rRD(rRD),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_sel(dc_sel),
    .dc_wdat(dc_wdat), .dc_ack(dc_ack), .dc_rdat(dc_rdat), .lsu_stall(lsu_stall),
    .wLDDAT(wLDDAT), .wLDRD(wLDRD), .wLDWE(wLDWE), .lsu_err(lsu_err)
  );

  always #5 gclk = ~gclk;

  int          n_chk = 0;
  int          n_err = 0;
  int          stallCnt = 0;
  logic [36:0] q[$];
  logic [36:0] e_mon;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  // Writeback monitor: every strobe must match the oldest expected load.
  always @(negedge gclk) begin
    if (lsu_stall) stallCnt++;
    if (wLDWE) begin
      if (q.size() == 0) begin
        chk("unexpected_wb", {31'd0, wLDWE}, 32'd0);
      end else begin
        e_mon = q.pop_front();
        chk("wb_data", wLDDAT, e_mon[31:0]);
        chk("wb_rd", {27'd0, wLDRD}, {27'd0, e_mon[36:32]});
      end
    end
  end

  task automatic step();
    @(posedge gclk);
    #1;
  endtask

  task automatic drive(input logic ld, input logic st, input logic [3:0] sel,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] rd);
    x_en = 1'b1; xLSU_LD = ld; xLSU_ST = st;
    rDWBSEL = sel; rRESULT = addr; xSTDATA = data; rRD = rd;
    step();
    x_en = 1'b0; xLSU_LD = 1'b0; xLSU_ST = 1'b0;
  endtask

  task automatic ack(input int waits, input logic [31:0] rdat);
    for (int i = 0; i < waits; i++) step();
    dc_ack = 1'b1; dc_rdat = rdat;
    step();
    dc_ack = 1'b0;
  endtask

  logic [3:0]  alSel[5] = '{4'h4, 4'h1, 4'hC, 4'h3, 4'h5};
  logic [31:0] alExp[5] = '{32'h22, 32'h44, 32'h1122, 32'h3344, 32'h0};

  initial begin
    grst = 1'b1; x_en = 1'b0; xLSU_LD = 1'b0; xLSU_ST = 1'b0;
    rRESULT = '0; rDWBSEL = '0; xSTDATA = '0; rRD = '0; dc_ack = 1'b0; dc_rdat = '0;
    #12;
    chk("rst_req",   {31'd0, dc_req}, 32'd0);
    chk("rst_wdat",  dc_wdat, 32'd0);
    chk("rst_lddat", wLDDAT, 32'd0);
    chk("rst_err",   {31'd0, lsu_err}, 32'd0);
    @(posedge gclk); #3 grst = 1'b0;
    step();

    // Byte load, zero-wait
    stallCnt = 0;
    q.push_back({5'd5, 32'h00000033});
    drive(1'b1, 1'b0, 4'h2, 32'h00001002, 32'h0, 5'd5);
    chk("bl_req",  {31'd0, dc_req}, 32'd1);
    chk("bl_addr", {2'b0, dc_addr}, 32'h00000400);
    chk("bl_we",   {31'd0, dc_we}, 32'd0);
    chk("bl_sel",  {28'd0, dc_sel}, 32'h2);
    ack(0, 32'h11223344);
    chk("bl_wbN2", {31'd0, wLDWE}, 32'd1);
    step();
    chk("bl_wbN3", {31'd0, wLDWE}, 32'd0);
    chk("bl_stall", stallCnt, 32'd0);

    // Half store, 3 wait states
    stallCnt = 0;
    drive(1'b0, 1'b1, 4'h3, 32'h00003000, 32'hDEADBEEF, 5'd9);
    chk("hs_wdat",  dc_wdat, 32'hBEEFBEEF);
    chk("hs_we",    {31'd0, dc_we}, 32'd1);
    chk("hs_stall0", {31'd0, lsu_stall}, 32'd1);
    ack(3, 32'h0);
    chk("hs_stall", stallCnt, 32'd3);
    chk("hs_reqlo", {31'd0, dc_req}, 32'd0);

    // Back-to-back loads, issue in the writeback cycle
    q.push_back({5'd3, 32'hCAFEBABE});
    drive(1'b1, 1'b0, 4'hF, 32'h00002000, 32'h0, 5'd3);
    ack(0, 32'hCAFEBABE);
    chk("b2b_gap", {31'd0, dc_req}, 32'd0);
    q.push_back({5'd4, 32'h00000089});
    drive(1'b1, 1'b0, 4'h8, 32'h00002004, 32'h0, 5'd4);
    chk("b2b_req2",  {31'd0, dc_req}, 32'd1);
    chk("b2b_addr2", {2'b0, dc_addr}, 32'h00000801);
    ack(0, 32'h89ABCDEF);
    step();
    chk("hold_rd",  {27'd0, wLDRD}, 32'd4);
    chk("hold_dat", wLDDAT, 32'h00000089);

    // Remaining load alignments, one wait state each
    for (int i = 0; i < 5; i++) begin
      q.push_back({5'(10 + i), alExp[i]});
      drive(1'b1, 1'b0, alSel[i], 32'h00000100 + 32'(4 * i), 32'h0, 5'(10 + i));
      ack(1, 32'h11223344);
    end
    step();

    // Store replication and load-wins-over-store
    drive(1'b0, 1'b1, 4'h1, 32'h00000040, 32'h000000A5, 5'd0);
    chk("sb_wdat", dc_wdat, 32'hA5A5A5A5);
    ack(0, 32'h0);
    drive(1'b0, 1'b1, 4'hF, 32'h00000044, 32'h12345678, 5'd0);
    chk("sw_wdat", dc_wdat, 32'h12345678);
    ack(0, 32'h0);
    q.push_back({5'd6, 32'h00005566});
    drive(1'b1, 1'b1, 4'hC, 32'h00000048, 32'h0000FFFF, 5'd6);
    chk("ldst_we", {31'd0, dc_we}, 32'd0);
    ack(0, 32'h55667788);
    step();

    // FSL select dropped
    drive(1'b1, 1'b0, 4'h0, 32'h00000050, 32'h0, 5'd2);
    chk("fsl_req", {31'd0, dc_req}, 32'd0);
    step(); step();
    chk("fsl_req2", {31'd0, dc_req}, 32'd0);

    // Stray ack while idle
    dc_ack = 1'b1;
    #1 chk("stray_stall", {31'd0, lsu_stall}, 32'd0);
    step();
    dc_ack = 1'b0;
    chk("stray_req", {31'd0, dc_req}, 32'd0);

    // Mid-request reset with a late ack
    drive(1'b1, 1'b0, 4'hF, 32'h00000060, 32'h0, 5'd8);
    step();
    #3 grst = 1'b1;
    #1;
    chk("mr_req",   {31'd0, dc_req}, 32'd0);
    chk("mr_stall", {31'd0, lsu_stall}, 32'd0);
    chk("mr_addr",  {2'b0, dc_addr}, 32'd0);
    chk("mr_sel",   {28'd0, dc_sel}, 32'd0);
    chk("mr_wdat",  dc_wdat, 32'd0);
    chk("mr_lddat", wLDDAT, 32'd0);
    chk("mr_ldrd",  {27'd0, wLDRD}, 32'd0);
    @(posedge gclk); #3 grst = 1'b0;
    dc_ack = 1'b1; dc_rdat = 32'hFFFFFFFF;
    step(); step();
    dc_ack = 1'b0;
    chk("mr_late_req", {31'd0, dc_req}, 32'd0);
    chk("mr_late_dat", wLDDAT, 32'd0);

`ifdef AEXM_LSU_TIMEOUT_EN
    q.push_back({5'd7, 32'hFFFFFFFF});
    drive(1'b1, 1'b0, 4'hF, 32'h00000070, 32'h0, 5'd7);
    for (int i = 0; i < 400 && !lsu_err; i++) step();
    chk("to_err", {31'd0, lsu_err}, 32'd1);
    chk("to_req", {31'd0, dc_req}, 32'd0);
    step(); step();
    chk("to_sticky", {31'd0, lsu_err}, 32'd1);
`else
    chk("no_to_err", {31'd0, lsu_err}, 32'd0);
`endif

    step(); step();
    chk("queue_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
`default_nettype wire
